// File: rtl/dmem_responder.sv
// dmem_responder: word storage behind a single-outstanding req/ready port.
// A request is captured in IDLE and held for WAIT_CYCLES wait states. It then
// completes with a one-cycle ready pulse. Misaligned or out-of-range accesses
// complete with err=1 and leave the storage untouched.
// Optional feature: define DMEM_RESP_BYTE_EN_EN to add a be[3:0] input.
// With be present, a write updates only the enabled bytes (be[0] = bits 7:0).
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_RESP_BYTE_EN_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt;

    // Request fields held stable for the whole transaction.
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Fields of the access being completed this cycle.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
`ifdef DMEM_RESP_BYTE_EN_EN
    logic [3:0]  lat_be;
    logic [3:0]  cur_be;
`endif

    logic             acc_err;
    logic             enter_resp;
    logic [IDX_W-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    // State and wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so ordering between always_ff blocks is irrelevant.
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) next_state = RESP;
                else             next_cnt   = cnt - 4'd1;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef DMEM_RESP_BYTE_EN_EN
            lat_be    <= '0;
`endif
        end else if (state == IDLE && req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
`ifdef DMEM_RESP_BYTE_EN_EN
            lat_be    <= be;
`endif
        end
    end

    // With zero wait states IDLE enters RESP on the capture edge itself,
    // so that access has to be decoded from the live inputs.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
`ifdef DMEM_RESP_BYTE_EN_EN
            cur_be    = be;
`endif
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
`ifdef DMEM_RESP_BYTE_EN_EN
            cur_be    = lat_be;
`endif
        end
    end

    assign acc_err    = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_LIM);
    assign idx        = cur_addr[IDX_W+1:2];
    assign enter_resp = rst_n && (state != RESP) && (next_state == RESP);

    // Storage write, performed on the edge that enters RESP.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; clearing the array would add a write port
        // per word for contents software must initialise anyway.
        if (enter_resp && cur_we && !acc_err) begin
`ifdef DMEM_RESP_BYTE_EN_EN
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
`else
            mem[idx] <= cur_wdata;
`endif
        end
    end

    // Response data and error flag, valid only in the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (enter_resp) begin
            rdata <= (!cur_we && !acc_err) ? mem[idx] : 32'h0;
            err   <= acc_err;
        end else begin
            rdata <= '0;
            err   <= 1'b0;
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the datapath's data-memory port; owns the word storage.
- Accepts one read or write request at a time over a req/ready handshake, inserts configurable wait states, then completes the access.
- Sits between the CPU's load/store path and the storage array; a multi-cycle core stalls on `ready`.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states inserted between request capture and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  initiator requests an access; `we`/`addr`/`wdata` are valid while high.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- wdata  input  32  write data.
- rdata  output  32  read data; valid only in the cycle `ready` is high.
- ready  output  1  one-cycle completion pulse.
- err  output  1  high with `ready` when the access was rejected.
- busy  output  1  high from request capture until the ready cycle, inclusive.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - `rdata`=0, `ready`=0, `err`=0, `busy`=0.
  - FSM returns to IDLE and the wait counter is cleared.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with `req`=1, latch `we`/`addr`/`wdata` into internal registers.
  - Then go to WAIT, or directly to RESP if WAIT_CYCLES=0.
  - `busy` goes high the cycle after capture.
- WAIT:
  - Counter starts at WAIT_CYCLES-1 and decrements each edge.
  - Leave for RESP when the counter is 0.
  - Input changes during WAIT are ignored; latched values are used.
- RESP:
  - `ready`=1 for exactly one cycle, and the access is performed on entry.
  - Read: `rdata` = word at latched `addr[31:2]`.
  - Write: storage word updated at the edge entering RESP; `rdata`=0.
  - Next state is always IDLE. `rdata` returns to 0 when `ready` drops.
- Latency: the req-capture edge to the `ready`-high cycle is WAIT_CYCLES+1 clocks.
- Back-to-back: if `req` is still high in the IDLE cycle after RESP, it is captured as a new request. Initiator must drop `req` in the ready cycle to avoid a repeat access.
- Errors:
  - Triggers: latched `addr[1:0]`≠0 (misaligned), or `addr[31:2]` ≥ DEPTH_WORDS (out of range).
  - Still goes through WAIT/RESP with the normal latency.
  - In RESP: `ready`=1, `err`=1, no storage write, `rdata`=0.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset asserted mid-transaction:
  - Transaction is abandoned and no `ready` is produced.
  - A write not yet at the RESP edge is not committed.

Optional Feature:
- Macro DMEM_RESP_BYTE_EN_EN adds input port `be[3:0]`, latched with the request.
- With the macro, on write:
  - Only bytes with `be[i]`=1 are updated (`be[0]` = bits 7:0).
  - `be`=0000 on a write is accepted as a no-op write (`ready`=1, `err`=0).
  - Reads ignore `be`.
- Without the macro: no `be` port; writes always update all 4 bytes.

Test Plan:
- Reset (WAIT_CYCLES=2): hold `rst_n`=0, then release -> `ready`/`err`/`busy`/`rdata` all 0; `req`=0 keeps `busy`=0 indefinitely.
- Write then read: write `addr`=0x10, `wdata`=0xDEADBEEF; then read `addr`=0x10 -> each `ready` pulse arrives exactly 3 clocks after capture; read `rdata`=0xDEADBEEF, `err`=0.
- Back-to-back:
  - Hold `req`=1 across two write transactions to 0x0 and 0x4 (0x11111111, 0x22222222).
  - Expect two `ready` pulses 4 clocks apart; both words read back correctly.
- Errors: read `addr`=0x6 -> `ready`=1, `err`=1, `rdata`=0; write `addr`=0x100 (DEPTH_WORDS=64) -> `err`=1, and word 0 is unchanged on readback.
- Zero wait states (WAIT_CYCLES=0): read -> `ready` 1 clock after capture.
- Reset mid-write: pull `rst_n` low in WAIT during a write of 0xCAFEF00D to 0x20 -> no `ready`; readback of 0x20 returns the old value.
- Byte enables (DMEM_RESP_BYTE_EN_EN defined): word 0x0=0xAABBCCDD, write 0x11223344 with `be`=0101 -> readback 0xAA22CC44.
